// File: rtl/jtag_dbg_pkg.sv
// jtag_dbg_pkg
// Shared definitions for the JTAG debug TAP: TAP state encoding, IR codes,
// debug data-register field positions/lengths and debug module-id values.
// Build option: define JTAG_DBG_IDCODE_EN to include the IDCODE instruction
// and make it the IR reset value; otherwise IDCODE decodes as BYPASS and
// the IR resets to BYPASS.
package jtag_dbg_pkg;

  typedef enum logic [3:0] {
    ST_TEST_LOGIC_RESET,
    ST_RUN_TEST_IDLE,
    ST_SELECT_DR,
    ST_CAPTURE_DR,
    ST_SHIFT_DR,
    ST_EXIT1_DR,
    ST_PAUSE_DR,
    ST_EXIT2_DR,
    ST_UPDATE_DR,
    ST_SELECT_IR,
    ST_CAPTURE_IR,
    ST_SHIFT_IR,
    ST_EXIT1_IR,
    ST_PAUSE_IR,
    ST_EXIT2_IR,
    ST_UPDATE_IR
  } tap_state_e;

  // Data register currently placed between TDI and TDO
  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_DEBUG
  } dr_sel_e;

  localparam int IR_LEN = 8;
  localparam logic [IR_LEN-1:0] IR_DEBUG   = 8'h32;
  localparam logic [IR_LEN-1:0] IR_IDCODE  = 8'h01;
  localparam logic [IR_LEN-1:0] IR_BYPASS  = 8'hFF;
  localparam logic [IR_LEN-1:0] IR_CAPTURE = 8'b0000_0101;

`ifdef JTAG_DBG_IDCODE_EN
  localparam logic [IR_LEN-1:0] IR_RESET = IR_IDCODE;
`else
  localparam logic [IR_LEN-1:0] IR_RESET = IR_BYPASS;
`endif

  // Debug DR geometry. The longest scan (burst setup) defines the register
  // length; shorter scans are right-aligned at its MSB end.
  localparam int DBG_DR_LEN     = 53;
  localparam int BURST_LEN      = 53;
  localparam int MODSEL_LEN     = 3;
  localparam int IDCODE_LEN     = 32;
  localparam int BURST_FLAG_POS = 52;
  localparam int BURST_OP_LSB   = 48;
  localparam int BURST_ADDR_LSB = 16;
  localparam int BURST_CNT_LSB  = 0;
  localparam int MODSEL_FLAG    = 2;

  localparam logic [1:0] MOD_WISHBONE = 2'b00;
  localparam logic [1:0] MOD_CPU0     = 2'b01;
  localparam logic [1:0] MOD_CPU1     = 2'b10;
  localparam logic [1:0] MOD_RESERVED = 2'b11;

  // Undefined IR codes fall through to BYPASS.
  function automatic dr_sel_e ir_decode(input logic [IR_LEN-1:0] ir);
    dr_sel_e sel;
    sel = DR_BYPASS;
    if (ir == IR_DEBUG) begin
      sel = DR_DEBUG;
    end
`ifdef JTAG_DBG_IDCODE_EN
    else if (ir == IR_IDCODE) begin
      sel = DR_IDCODE;
    end
`endif
    return sel;
  endfunction

endpackage

// File: rtl/jtag_dbg_tap_fsm.sv
// jtag_tap_fsm
// IEEE 1149.1 16-state TAP controller.
// Ports: clk/rst_n (TCK, async active-low reset), tms (sampled on posedge);
// outputs are one-hot strobes, high while the controller is in that state.
module jtag_tap_fsm
  import jtag_dbg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tms,
  output logic tlr,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir
);

  tap_state_e state_reg;
  tap_state_e state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_TEST_LOGIC_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_TEST_LOGIC_RESET: state_next = tms ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
      ST_RUN_TEST_IDLE:    state_next = tms ? ST_SELECT_DR : ST_RUN_TEST_IDLE;
      ST_SELECT_DR:        state_next = tms ? ST_SELECT_IR : ST_CAPTURE_DR;
      ST_CAPTURE_DR:       state_next = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_SHIFT_DR:         state_next = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_EXIT1_DR:         state_next = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
      ST_PAUSE_DR:         state_next = tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
      ST_EXIT2_DR:         state_next = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
      ST_UPDATE_DR:        state_next = tms ? ST_SELECT_DR : ST_RUN_TEST_IDLE;
      ST_SELECT_IR:        state_next = tms ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
      ST_CAPTURE_IR:       state_next = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_SHIFT_IR:         state_next = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_EXIT1_IR:         state_next = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
      ST_PAUSE_IR:         state_next = tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
      ST_EXIT2_IR:         state_next = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
      ST_UPDATE_IR:        state_next = tms ? ST_SELECT_DR : ST_RUN_TEST_IDLE;
      default:             state_next = ST_TEST_LOGIC_RESET;
    endcase
  end

  assign tlr        = (state_reg == ST_TEST_LOGIC_RESET);
  assign capture_dr = (state_reg == ST_CAPTURE_DR);
  assign shift_dr   = (state_reg == ST_SHIFT_DR);
  assign update_dr  = (state_reg == ST_UPDATE_DR);
  assign capture_ir = (state_reg == ST_CAPTURE_IR);
  assign shift_ir   = (state_reg == ST_SHIFT_IR);
  assign update_ir  = (state_reg == ST_UPDATE_IR);

endmodule

// File: rtl/jtag_dbg_tap.sv
// jtag_dbg_tap
// JTAG debug target: TAP controller, 8-bit IR, and a 53-bit debug DR that
// decodes module-select (3-bit) and burst-setup (53-bit) scans into
// registered commands handed to the debug bridge via cmd_valid/cmd_ack.
// Ports: TCK (only clock), system_reset_n (async, active-low), TMS/TDI in,
// TDO/tdo_oe out, module_id, cmd_valid/opcode/addr/count, cmd_ack in,
// cmd_overrun (sticky dropped-command flag).
// Build option: JTAG_DBG_IDCODE_EN enables the IDCODE instruction.
module jtag_dbg_tap
  import jtag_dbg_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic        TCK,
  input  logic        system_reset_n,
  input  logic        TMS,
  input  logic        TDI,
  output logic        TDO,
  output logic        tdo_oe,
  output logic [1:0]  module_id,
  output logic        cmd_valid,
  output logic [3:0]  cmd_opcode,
  output logic [31:0] cmd_addr,
  output logic [15:0] cmd_count,
  input  logic        cmd_ack,
  output logic        cmd_overrun
);

  logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_fsm (
    .clk        (TCK),
    .rst_n      (system_reset_n),
    .tms        (TMS),
    .tlr        (tlr),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir)
  );

  logic [IR_LEN-1:0]     ir_reg;
  logic [IR_LEN-1:0]     ir_sr_reg;
  logic [DBG_DR_LEN-1:0] dr_sr_reg;
  logic [DBG_DR_LEN-1:0] dr_capture_next;
  logic [DBG_DR_LEN-1:0] dr_shift_next;
  logic [5:0]            n_reg;
  logic [1:0]            module_id_reg;
  logic                  cmd_valid_reg;
  logic [3:0]            cmd_opcode_reg;
  logic [31:0]           cmd_addr_reg;
  logic [15:0]           cmd_count_reg;
  logic                  cmd_overrun_reg;
  logic                  tdo_reg;
  dr_sel_e               dr_sel;

  assign dr_sel = ir_decode(ir_reg);

  // Capture/shift values of the selected DR. All DRs share one register;
  // TDI enters at the MSB of the selected register's length.
  always_comb begin
    dr_capture_next = '0;
    dr_shift_next   = '0;
    case (dr_sel)
      DR_DEBUG: begin
        dr_capture_next = {48'b0, cmd_overrun_reg, cmd_valid_reg, module_id_reg, 1'b0};
        dr_shift_next   = {TDI, dr_sr_reg[DBG_DR_LEN-1:1]};
      end
      DR_IDCODE: begin
        dr_capture_next = {{(DBG_DR_LEN-IDCODE_LEN){1'b0}}, IDCODE_VAL};
        dr_shift_next   = {{(DBG_DR_LEN-IDCODE_LEN){1'b0}}, TDI, dr_sr_reg[IDCODE_LEN-1:1]};
      end
      default: begin
        dr_capture_next = '0;
        dr_shift_next   = {{(DBG_DR_LEN-1){1'b0}}, TDI};
      end
    endcase
  end

  // After n shifts the last n scanned bits sit at the top of the register,
  // so a 3-bit word is sr[52:50] and a 53-bit word is the whole register.
  logic debug_update;
  logic modsel_hit;
  logic burst_hit;
  logic valid_after_ack;

  assign debug_update    = update_dr && (dr_sel == DR_DEBUG);
  assign modsel_hit      = debug_update && (n_reg == 6'(MODSEL_LEN))
                           && dr_sr_reg[DBG_DR_LEN-MODSEL_LEN+MODSEL_FLAG];
  assign burst_hit       = debug_update && (n_reg == 6'(BURST_LEN))
                           && !dr_sr_reg[BURST_FLAG_POS];
  // An ack on the same edge frees the slot for the incoming command.
  assign valid_after_ack = cmd_valid_reg && !cmd_ack;

  always_ff @(posedge TCK or negedge system_reset_n) begin
    if (!system_reset_n) begin
      ir_reg    <= IR_RESET;
      ir_sr_reg <= '0;
    end else begin
      if (tlr) begin
        ir_reg <= IR_RESET;
      end else if (update_ir) begin
        ir_reg <= ir_sr_reg;
      end
      if (capture_ir) begin
        ir_sr_reg <= IR_CAPTURE;
      end else if (shift_ir) begin
        ir_sr_reg <= {TDI, ir_sr_reg[IR_LEN-1:1]};
      end
    end
  end

  always_ff @(posedge TCK or negedge system_reset_n) begin
    if (!system_reset_n) begin
      dr_sr_reg <= '0;
      n_reg     <= '0;
    end else if (capture_dr) begin
      dr_sr_reg <= dr_capture_next;
      n_reg     <= '0;
    end else if (shift_dr) begin
      dr_sr_reg <= dr_shift_next;
      if (n_reg != 6'd63) begin
        n_reg <= n_reg + 6'd1;
      end
    end
  end

  always_ff @(posedge TCK or negedge system_reset_n) begin
    if (!system_reset_n) begin
      module_id_reg   <= MOD_WISHBONE;
      cmd_valid_reg   <= 1'b0;
      cmd_opcode_reg  <= '0;
      cmd_addr_reg    <= '0;
      cmd_count_reg   <= '0;
      cmd_overrun_reg <= 1'b0;
    end else begin
      if (modsel_hit) begin
        module_id_reg <= dr_sr_reg[DBG_DR_LEN-MODSEL_LEN +: 2];
      end
      if (burst_hit && !valid_after_ack) begin
        cmd_valid_reg  <= 1'b1;
        cmd_opcode_reg <= dr_sr_reg[BURST_OP_LSB +: 4];
        cmd_addr_reg   <= dr_sr_reg[BURST_ADDR_LSB +: 32];
        cmd_count_reg  <= dr_sr_reg[BURST_CNT_LSB +: 16];
      end else if (cmd_ack) begin
        cmd_valid_reg <= 1'b0;
      end
      if (tlr) begin
        cmd_overrun_reg <= 1'b0;
      end else if (burst_hit && valid_after_ack) begin
        cmd_overrun_reg <= 1'b1;
      end
    end
  end

  // TDO changes on the falling edge so the host samples a stable bit.
  always_ff @(negedge TCK or negedge system_reset_n) begin
    if (!system_reset_n) begin
      tdo_reg <= 1'b0;
    end else if (shift_ir) begin
      tdo_reg <= ir_sr_reg[0];
    end else if (shift_dr) begin
      tdo_reg <= dr_sr_reg[0];
    end else begin
      tdo_reg <= 1'b0;
    end
  end

  assign TDO         = tdo_reg;
  assign tdo_oe      = shift_ir || shift_dr;
  assign module_id   = module_id_reg;
  assign cmd_valid   = cmd_valid_reg;
  assign cmd_opcode  = cmd_opcode_reg;
  assign cmd_addr    = cmd_addr_reg;
  assign cmd_count   = cmd_count_reg;
  assign cmd_overrun = cmd_overrun_reg;

endmodule
